// File: rtl/pw_check_ctrl.sv
// Key-entry controller: gathers an 8-byte key from UART RX, checks it against SECRET,
// returns a one-byte verdict over the TX handshake and enforces a lockout after repeated failures.
module pw_check_ctrl #(
  parameter logic [63:0] SECRET         = 64'h1F6C19D35D1F6822,
  parameter logic [7:0]  RESP_OK        = 8'h59,
  parameter logic [7:0]  RESP_BAD       = 8'h4E,
  parameter int          MAX_FAIL       = 3,
  parameter int          LOCKOUT_CYCLES = 4096,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       unlocked,
  output logic       locked,
  output logic [3:0] fail_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int LW = $clog2(LOCKOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_COMPARE,
    ST_SEND,
    ST_LOCKED
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [2:0]    r_byte_idx;
  logic [63:0]   r_key;
  logic [TW-1:0] r_idle;
  logic [LW-1:0] r_lock_cnt;
  logic          r_tx_valid;
  logic [7:0]    r_tx_data;
  logic          r_unlocked;
  logic [3:0]    r_fail_count;

  logic          w_match;
  logic          w_timeout;
  logic          w_lock_done;
  logic          w_handshake;
  logic [3:0]    w_fail_inc;

  // Full-width equality evaluated in one cycle; no byte-wise early exit.
  assign w_match     = (r_key == SECRET);
  assign w_timeout   = (r_state == ST_COLLECT) && !rx_valid && (r_byte_idx != 3'd0) &&
                       (r_idle == TW'(TIMEOUT_CYCLES - 1));
  assign w_lock_done = (r_state == ST_LOCKED) && (r_lock_cnt == LW'(LOCKOUT_CYCLES - 1));
  assign w_handshake = r_tx_valid && tx_ready;
  assign w_fail_inc  = (r_fail_count == 4'hF) ? r_fail_count : r_fail_count + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_COLLECT;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_COLLECT: if (rx_valid && (r_byte_idx == 3'd7)) w_next_state = ST_COMPARE;
      ST_COMPARE: w_next_state = ST_SEND;
      ST_SEND: begin
        if (w_handshake) begin
          w_next_state = (r_fail_count >= 4'(MAX_FAIL)) ? ST_LOCKED : ST_COLLECT;
        end
      end
      ST_LOCKED:  if (w_lock_done) w_next_state = ST_COLLECT;
      default:    w_next_state = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_idx   <= 3'd0;
      r_key        <= 64'd0;
      r_idle       <= '0;
      r_lock_cnt   <= '0;
      r_tx_valid   <= 1'b0;
      r_tx_data    <= 8'd0;
      r_unlocked   <= 1'b0;
      r_fail_count <= 4'd0;
    end else begin
      case (r_state)
        ST_COLLECT: begin
          if (rx_valid) begin
            r_key[8*r_byte_idx +: 8] <= rx_data;
            r_byte_idx               <= r_byte_idx + 3'd1;
            r_idle                   <= '0;
          end else if (w_timeout) begin
            r_byte_idx <= 3'd0;
            r_key      <= 64'd0;
            r_idle     <= '0;
          end else if (r_byte_idx != 3'd0) begin
            r_idle <= r_idle + 1'b1;
          end else begin
            r_idle <= '0;
          end
        end
        ST_COMPARE: begin
          // Key is scrubbed as soon as it has been judged.
          r_key      <= 64'd0;
          r_tx_valid <= 1'b1;
          if (w_match) begin
            r_tx_data    <= RESP_OK;
            r_unlocked   <= 1'b1;
            r_fail_count <= 4'd0;
          end else begin
            r_tx_data    <= RESP_BAD;
            r_fail_count <= w_fail_inc;
          end
        end
        ST_SEND: begin
          if (w_handshake) r_tx_valid <= 1'b0;
          r_lock_cnt <= '0;
        end
        ST_LOCKED: begin
          if (w_lock_done) begin
            r_lock_cnt   <= '0;
            r_fail_count <= 4'd0;
          end else begin
            r_lock_cnt <= r_lock_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign tx_valid   = r_tx_valid;
  assign tx_data    = r_tx_data;
  assign unlocked   = r_unlocked;
  assign locked     = (r_state == ST_LOCKED);
  assign fail_count = r_fail_count;

endmodule

// File: tb/tb_pw_check_ctrl.sv
// Directed bench for pw_check_ctrl: key match/mismatch, lockout, idle timeout,
// TX back-pressure and mid-key reset, with hand-computed expectations.
module tb_pw_check_ctrl;

  localparam logic [63:0] SECRET = 64'h1F6C19D35D1F6822;
  localparam logic [63:0] BADKEY = 64'h1F6C19D35D1F6823;

  logic       clk;
  logic       rst_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       unlocked;
  logic       locked;
  logic [3:0] fail_count;

  int n_cmp = 0;
  int n_err = 0;

  pw_check_ctrl #(
    .MAX_FAIL       (3),
    .LOCKOUT_CYCLES (16),
    .TIMEOUT_CYCLES (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .tx_ready   (tx_ready),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .unlocked   (unlocked),
    .locked     (locked),
    .fail_count (fail_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
    $display("check %-16s observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  // Called at a falling edge; strobes one byte across the next rising edge.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_key(input logic [63:0] k);
    for (int i = 0; i < 8; i++) send_byte(k[8*i +: 8]);
  endtask

  // Entered one cycle after the last byte; returns in the cycle tx_valid must be high.
  task automatic expect_verdict(input string tag, input logic [7:0] exp);
    check({tag, "_lat1"}, 64'(tx_valid), 64'd0);
    @(negedge clk);
    check({tag, "_valid"}, 64'(tx_valid), 64'd1);
    check({tag, "_data"}, 64'(tx_data), 64'(exp));
  endtask

  initial begin
    int cnt_lock;
    int cnt_tx;
    logic [63:0] sec;
    sec      = SECRET;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'd0);
    check("rst_unlocked", 64'(unlocked), 64'd0);
    check("rst_locked", 64'(locked), 64'd0);
    check("rst_fail", 64'(fail_count), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Wrong first byte
    send_key(BADKEY);
    expect_verdict("bad1", 8'h4E);
    @(negedge clk);
    check("bad1_drop", 64'(tx_valid), 64'd0);
    check("bad1_unlocked", 64'(unlocked), 64'd0);
    check("bad1_fail", 64'(fail_count), 64'd1);
    check("bad1_locked", 64'(locked), 64'd0);

    // Correct key
    send_key(SECRET);
    expect_verdict("ok1", 8'h59);
    @(negedge clk);
    check("ok1_drop", 64'(tx_valid), 64'd0);
    check("ok1_unlocked", 64'(unlocked), 64'd1);
    check("ok1_fail", 64'(fail_count), 64'd0);

    // Three failures in a row, then lockout
    send_key(BADKEY);
    expect_verdict("lk_a", 8'h4E);
    @(negedge clk);
    check("lk_a_fail", 64'(fail_count), 64'd1);
    send_key(BADKEY);
    expect_verdict("lk_b", 8'h4E);
    @(negedge clk);
    check("lk_b_fail", 64'(fail_count), 64'd2);
    check("lk_b_locked", 64'(locked), 64'd0);
    send_key(BADKEY);
    expect_verdict("lk_c", 8'h4E);
    check("lk_c_fail", 64'(fail_count), 64'd3);
    check("lk_c_unlocked", 64'(unlocked), 64'd1);
    cnt_lock = 0;
    cnt_tx   = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (locked) cnt_lock++;
      if (tx_valid) cnt_tx++;
      rx_valid = (i < 8);
      rx_data  = sec[8*(i%8) +: 8];
    end
    rx_valid = 1'b0;
    check("lock_len", 64'(cnt_lock), 64'd16);
    check("lock_no_tx", 64'(cnt_tx), 64'd0);
    check("lock_fail_clr", 64'(fail_count), 64'd0);
    check("lock_released", 64'(locked), 64'd0);
    send_key(SECRET);
    expect_verdict("post_lock", 8'h59);
    @(negedge clk);

    // Partial key abandoned by idle timeout
    for (int i = 0; i < 3; i++) send_byte(sec[8*i +: 8]);
    cnt_tx = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx_valid) cnt_tx++;
    end
    check("to_idle_no_tx", 64'(cnt_tx), 64'd0);
    send_key(SECRET);
    expect_verdict("to_key", 8'h59);
    cnt_tx = 0;
    repeat (10) begin
      @(negedge clk);
      if (tx_valid) cnt_tx++;
    end
    check("to_no_extra", 64'(cnt_tx), 64'd0);

    // Byte arriving on the very cycle the idle timer would expire is kept
    send_byte(sec[7:0]);
    repeat (31) @(negedge clk);
    for (int i = 1; i < 8; i++) send_byte(sec[8*i +: 8]);
    expect_verdict("to_edge", 8'h59);
    @(negedge clk);

    // TX back-pressure with stray bytes
    tx_ready = 1'b0;
    send_key(SECRET);
    expect_verdict("bp", 8'h59);
    for (int i = 0; i < 20; i++) begin
      check("bp_hold_valid", 64'(tx_valid), 64'd1);
      check("bp_hold_data", 64'(tx_data), 64'h59);
      rx_valid = (i >= 3 && i <= 6);
      rx_data  = 8'hAA;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    @(negedge clk);
    check("bp_release", 64'(tx_valid), 64'd0);
    send_key(SECRET);
    expect_verdict("bp_fresh", 8'h59);
    @(negedge clk);

    // Reset in the middle of a key
    send_key(BADKEY);
    expect_verdict("pre_rst", 8'h4E);
    @(negedge clk);
    check("pre_rst_fail", 64'(fail_count), 64'd1);
    for (int i = 0; i < 5; i++) send_byte(sec[8*i +: 8]);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx_valid", 64'(tx_valid), 64'd0);
    check("mid_rst_tx_data", 64'(tx_data), 64'd0);
    check("mid_rst_unlocked", 64'(unlocked), 64'd0);
    check("mid_rst_locked", 64'(locked), 64'd0);
    check("mid_rst_fail", 64'(fail_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_key(SECRET);
    expect_verdict("post_rst", 8'h59);
    @(negedge clk);
    check("post_rst_unlocked", 64'(unlocked), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
